hpdcache_prng: RTL and testbench
================================

Name: hpdcache_prng

Overview:
- Multi-channel Galois LFSR pseudo-random generator for HPDcache victim and way selection, and for any other random-choice arbiter in the cache.
- Each channel advances NSTEP LFSR steps per enabled cycle.
- Each channel's state can be reseeded at run time.
- Each channel also gives a uniformly scaled index in [0, RANGE-1].
- Sits beside the replacement/victim-select logic; one channel per consumer.

Parameters:
- WIDTH, 8, LFSR width; legal 8..16.
- NCHAN, 1, number of independent LFSR channels; legal 1..8.
- NSTEP, 1, LFSR steps per shift cycle; legal 1, 2, 4.
- RANGE, 4, index range for idx_o; legal 2..2^WIDTH.
- IDXW, $clog2(RANGE), derived (localparam), width of one index.
- CHW, (NCHAN>1 ? $clog2(NCHAN) : 1), derived (localparam), channel-select width.

Ports:
- clk_i  in  1  clock; all state updates on its rising edge.
- rst_ni  in  1  reset; asynchronous, active-low.
- shift_i  in  NCHAN  per-channel advance enable.
- seed_load_i  in  1  load seed_i into channel seed_chan_i this cycle.
- seed_chan_i  in  CHW  target channel of the seed load.
- seed_i  in  WIDTH  seed value.
- val_o  out  NCHAN*WIDTH  channel c state at bits [c*WIDTH +: WIDTH].
- idx_o  out  NCHAN*IDXW  channel c scaled index at bits [c*IDXW +: IDXW].

Behaviour:
- Feedback mask by WIDTH (low WIDTH bits used):
  - 8: 0x00E1, 9: 0x01EA, 10: 0x02E3, 11: 0x04E3, 12: 0x0AE2
  - 13: 0x10E3, 14: 0x20EA, 15: 0x41E2, 16: 0x81EE
- One step: next = {1'b0, q[WIDTH-1:1]}, then XOR with the mask if q[0]=1.
- NSTEP steps are chained combinationally within one cycle; no multicycle paths.
- Reset: channel c state = all-ones XOR c. Example, WIDTH=8: ch0=0xFF, ch1=0xFE, ch2=0xFD. This value is never zero.
- Reset takes effect immediately at any time, including mid-stream; all channels return to their reset values.
- Per-channel update priority each cycle:
  1. seed load (seed_load_i=1 and seed_chan_i=c)
  2. shift (shift_i[c]=1)
  3. hold
- A seed load overrides a same-cycle shift on that channel. The loaded value appears on val_o the next cycle, unshifted.
- Seed value 0 is illegal (LFSR lockup). The block loads all-ones instead; no error is flagged.
- A seed_chan_i value >= NCHAN is ignored: no channel changes.
- A seed load to one channel does not block shifts on other channels in the same cycle.
- val_o is the registered state (zero combinational latency from the flop); a new value is visible 1 cycle after shift_i.
- idx_o[c] = (val_c * RANGE) >> WIDTH. Computed with a WIDTH+IDXW+1-bit product, combinational from the state flop.
  - Always < RANGE.
  - Value 0 never occurs in the state, so index 0 is slightly under-represented; this is accepted.
- Period: 2^WIDTH-1 steps. NSTEP is a power of two and the period is odd, so the cycle period is also 2^WIDTH-1 shift cycles.

Optional Feature:
- Macro: HPDCACHE_PRNG_PERIOD_MON_EN.
- Defined: adds outputs wrap_o (NCHAN) and period_err_o (NCHAN), plus per-channel WIDTH-bit counters.
  - Each channel holds a reference value: its reset value, or the effective loaded seed.
  - The counter increments on each shift and clears on reset and on seed load.
  - When a shift makes the state equal the reference, wrap_o[c] pulses for 1 cycle and the counter clears.
  - If the count at that wrap is not 2^WIDTH-1, period_err_o[c] sets; it is sticky until reset.
  - Both outputs are 0 from reset.
- Undefined: these ports, counters and comparators are absent; functional behaviour is identical.

Test Plan:
- Shift stepping, WIDTH=8, NSTEP=1, reset then shift_i=1 for 3 cycles -> val_o 0xFF, 0x9E, 0x4F, 0xC6; idx_o (RANGE=4) 3, 2, 1, 3.
- Multi-step, NSTEP=2, WIDTH=8, one shift from reset -> val_o 0x4F; a second shift -> 0x63 (0xC6 shifted once more: 0x63).
- Multi-channel, NCHAN=2, shift_i=2'b10 once -> ch0 stays 0xFF; ch1 goes 0xFE -> 0x7F.
- Seed load with same-cycle shift on channel 0: seed_i=0x5A, shift_i[0]=1 -> 0x5A next cycle (load wins); seed_i=0x00 -> 0xFF; seed_chan_i=3 with NCHAN=2 -> no change.
- Reset asserted mid-stream after 10 shifts -> val_o returns to 0xFF/0xFE asynchronously, before the next clock edge.
- With HPDCACHE_PRNG_PERIOD_MON_EN, WIDTH=8, 255 consecutive shifts -> state back to 0xFF; wrap_o[0] pulses on cycle 255; period_err_o stays 0. Seed 0x01 then 255 shifts -> wrap with no error.

Source files
------------

// File: rtl/hpdcache_prng.sv
// hpdcache_prng: multi-channel Galois LFSR pseudo-random generator with
// per-channel seed reload and a uniformly scaled index per channel.
// Optional macro HPDCACHE_PRNG_PERIOD_MON_EN adds a per-channel period
// monitor (wrap_o pulse and sticky period_err_o).
module hpdcache_prng #(
  parameter  int unsigned WIDTH = 8,
  parameter  int unsigned NCHAN = 1,
  parameter  int unsigned NSTEP = 1,
  parameter  int unsigned RANGE = 4,
  localparam int unsigned IDXW  = $clog2(RANGE),
  localparam int unsigned CHW   = (NCHAN > 1) ? $clog2(NCHAN) : 1
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [NCHAN-1:0]       shift_i,
  input  logic                   seed_load_i,
  input  logic [CHW-1:0]         seed_chan_i,
  input  logic [WIDTH-1:0]       seed_i,
  output logic [NCHAN*WIDTH-1:0] val_o,
`ifdef HPDCACHE_PRNG_PERIOD_MON_EN
  output logic [NCHAN-1:0]       wrap_o,
  output logic [NCHAN-1:0]       period_err_o,
`endif
  output logic [NCHAN*IDXW-1:0]  idx_o
);

  // Product width large enough for (2^WIDTH-1) * RANGE with RANGE up to 2^IDXW
  localparam int unsigned PW = WIDTH + IDXW + 1;

  // Feedback mask table, maximal-length taps per supported width
  function automatic logic [15:0] fb_mask(input int unsigned w);
    case (w)
      8:       fb_mask = 16'h00E1;
      9:       fb_mask = 16'h01EA;
      10:      fb_mask = 16'h02E3;
      11:      fb_mask = 16'h04E3;
      12:      fb_mask = 16'h0AE2;
      13:      fb_mask = 16'h10E3;
      14:      fb_mask = 16'h20EA;
      15:      fb_mask = 16'h41E2;
      default: fb_mask = 16'h81EE;
    endcase
  endfunction

  localparam logic [WIDTH-1:0] MASK = WIDTH'(fb_mask(WIDTH));

  // NSTEP chained Galois steps, all within one cycle
  function automatic logic [WIDTH-1:0] lfsr_nstep(input logic [WIDTH-1:0] q);
    logic [WIDTH-1:0] v;
    v = q;
    for (int unsigned s = 0; s < NSTEP; s++) begin
      v = {1'b0, v[WIDTH-1:1]} ^ (v[0] ? MASK : '0);
    end
    return v;
  endfunction

  // An all-zero seed would lock the LFSR; substitute all-ones
  logic [WIDTH-1:0] seed_eff;
  assign seed_eff = (seed_i == '0) ? '1 : seed_i;

  for (genvar c = 0; c < NCHAN; c++) begin : g_chan
    localparam logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b1}} ^ WIDTH'(c);

    logic [WIDTH-1:0] state_q;
    logic [WIDTH-1:0] state_d;
    logic [WIDTH-1:0] stepped;
    logic             load_hit;
    logic [PW-1:0]    prod;

    // Out-of-range channel numbers never match any channel
    assign load_hit = seed_load_i && (seed_chan_i == CHW'(c));
    assign stepped  = lfsr_nstep(state_q);

    // Next state: seed load beats shift beats hold
    always_comb begin
      state_d = state_q;
      if (load_hit) begin
        state_d = seed_eff;
      end else if (shift_i[c]) begin
        state_d = stepped;
      end
    end

    // Channel state register
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        state_q <= RST_VAL;
      end else begin
        state_q <= state_d;
      end
    end

    // Scaled index straight from the state flop
    assign prod = PW'(state_q) * PW'(RANGE);
    assign val_o[c*WIDTH +: WIDTH] = state_q;
    assign idx_o[c*IDXW +: IDXW]   = IDXW'(prod >> WIDTH);

`ifdef HPDCACHE_PRNG_PERIOD_MON_EN
    logic [WIDTH-1:0] ref_q;
    logic [WIDTH-1:0] cnt_q;
    logic             wrap_q;
    logic             err_q;

    // Period monitor: count shifts until the state returns to its reference
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        ref_q  <= RST_VAL;
        cnt_q  <= '0;
        wrap_q <= 1'b0;
        err_q  <= 1'b0;
      end else if (load_hit) begin
        ref_q  <= seed_eff;
        cnt_q  <= '0;
        wrap_q <= 1'b0;
      end else if (shift_i[c]) begin
        if (stepped == ref_q) begin
          wrap_q <= 1'b1;
          cnt_q  <= '0;
          if ((cnt_q + WIDTH'(1)) != {WIDTH{1'b1}}) begin
            err_q <= 1'b1;
          end
        end else begin
          wrap_q <= 1'b0;
          cnt_q  <= cnt_q + WIDTH'(1);
        end
      end else begin
        wrap_q <= 1'b0;
      end
    end

    assign wrap_o[c]       = wrap_q;
    assign period_err_o[c] = err_q;
`endif
  end

endmodule

// File: tb/tb_hpdcache_prng.sv
// Self-checking bench for hpdcache_prng. Three instances cover NSTEP 1/2/4,
// widths 8 and 12, non-power-of-two RANGE and RANGE = 2^WIDTH. The model
// tracks each channel as a position on the precomputed LFSR orbit.
module tb_hpdcache_prng;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [2:0]  shift_a;
  logic [1:0]  shift_b;
  logic [0:0]  shift_c;
  logic        seed_ld;
  logic [1:0]  chan_a;
  logic [0:0]  chan_b;
  logic [0:0]  chan_c;
  logic [7:0]  seed8;
  logic [11:0] seed12;
  logic [23:0] val_a;
  logic [5:0]  idx_a;
  logic [15:0] val_b;
  logic [5:0]  idx_b;
  logic [11:0] val_c;
  logic [11:0] idx_c;
`ifdef HPDCACHE_PRNG_PERIOD_MON_EN
  logic [2:0]  wrap_a, err_a;
  logic [1:0]  wrap_b, err_b;
  logic [0:0]  wrap_c, err_c;
`endif

  hpdcache_prng #(.WIDTH(8), .NCHAN(3), .NSTEP(1), .RANGE(4)) dut_a (
    .clk_i(clk), .rst_ni(rst_n), .shift_i(shift_a), .seed_load_i(seed_ld),
    .seed_chan_i(chan_a), .seed_i(seed8), .val_o(val_a),
`ifdef HPDCACHE_PRNG_PERIOD_MON_EN
    .wrap_o(wrap_a), .period_err_o(err_a),
`endif
    .idx_o(idx_a));

  hpdcache_prng #(.WIDTH(8), .NCHAN(2), .NSTEP(2), .RANGE(6)) dut_b (
    .clk_i(clk), .rst_ni(rst_n), .shift_i(shift_b), .seed_load_i(seed_ld),
    .seed_chan_i(chan_b), .seed_i(seed8), .val_o(val_b),
`ifdef HPDCACHE_PRNG_PERIOD_MON_EN
    .wrap_o(wrap_b), .period_err_o(err_b),
`endif
    .idx_o(idx_b));

  hpdcache_prng #(.WIDTH(12), .NCHAN(1), .NSTEP(4), .RANGE(4096)) dut_c (
    .clk_i(clk), .rst_ni(rst_n), .shift_i(shift_c), .seed_load_i(seed_ld),
    .seed_chan_i(chan_c), .seed_i(seed12), .val_o(val_c),
`ifdef HPDCACHE_PRNG_PERIOD_MON_EN
    .wrap_o(wrap_c), .period_err_o(err_c),
`endif
    .idx_o(idx_c));

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  // Orbit tables: table 0 is width 8, table 1 is width 12
  int unsigned orb     [2][4096];
  int unsigned pos_tab [2][4096];
  int unsigned per     [2];
  int unsigned pa [3];
  int unsigned pb [2];
  int unsigned pc [1];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int unsigned mask_of(input int unsigned w);
    return (w == 8) ? 32'h00E1 : 32'h0AE2;
  endfunction

  function automatic int unsigned idx_ref(input int unsigned v, input int unsigned w,
                                          input int unsigned r);
    longint unsigned p;
    p = longint'(v) * longint'(r);
    return int'(p >> w);
  endfunction

  task automatic build_tables();
    int unsigned w, v;
    for (int t = 0; t < 2; t++) begin
      w = (t == 0) ? 8 : 12;
      per[t] = (1 << w) - 1;
      v = per[t];
      for (int unsigned i = 0; i < per[t]; i++) begin
        orb[t][i] = v;
        pos_tab[t][v] = i;
        v = (v & 1) ? ((v >> 1) ^ mask_of(w)) : (v >> 1);
      end
    end
  endtask

  function automatic int unsigned load_pos(input int t, input int unsigned s);
    return (s == 0) ? pos_tab[t][per[t]] : pos_tab[t][s];
  endfunction

  task automatic model_reset();
    for (int c = 0; c < 3; c++) pa[c] = pos_tab[0][255 ^ c];
    for (int c = 0; c < 2; c++) pb[c] = pos_tab[0][255 ^ c];
    pc[0] = pos_tab[1][4095];
  endtask

  task automatic model_step();
    for (int c = 0; c < 3; c++) begin
      if (seed_ld && chan_a == c)  pa[c] = load_pos(0, seed8);
      else if (shift_a[c])         pa[c] = (pa[c] + 1) % per[0];
    end
    for (int c = 0; c < 2; c++) begin
      if (seed_ld && chan_b == c)  pb[c] = load_pos(0, seed8);
      else if (shift_b[c])         pb[c] = (pb[c] + 2) % per[0];
    end
    if (seed_ld && chan_c == 0)    pc[0] = load_pos(1, seed12);
    else if (shift_c[0])           pc[0] = (pc[0] + 4) % per[1];
  endtask

  task automatic check_all(input string ph);
    int unsigned v;
    for (int c = 0; c < 3; c++) begin
      v = orb[0][pa[c]];
      check($sformatf("%s val_a[%0d]", ph, c), 64'(val_a[c*8 +: 8]), 64'(v));
      check($sformatf("%s idx_a[%0d]", ph, c), 64'(idx_a[c*2 +: 2]), 64'(idx_ref(v, 8, 4)));
    end
    for (int c = 0; c < 2; c++) begin
      v = orb[0][pb[c]];
      check($sformatf("%s val_b[%0d]", ph, c), 64'(val_b[c*8 +: 8]), 64'(v));
      check($sformatf("%s idx_b[%0d]", ph, c), 64'(idx_b[c*3 +: 3]), 64'(idx_ref(v, 8, 6)));
    end
    v = orb[1][pc[0]];
    check($sformatf("%s val_c", ph), 64'(val_c), 64'(v));
    check($sformatf("%s idx_c", ph), 64'(idx_c), 64'(idx_ref(v, 12, 4096)));
  endtask

  // Inputs are set at a negedge; this advances one clock and checks everything
  task automatic run_cycle(input string ph);
    model_step();
    @(posedge clk);
    #1;
    check_all(ph);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    shift_a = '0; shift_b = '0; shift_c = '0;
    seed_ld = 1'b0; chan_a = '0; chan_b = '0; chan_c = '0;
    seed8 = '0; seed12 = '0;
  endtask

  logic [7:0] tp1_v [3];
  logic [1:0] tp1_i [3];
  logic [7:0] tp2_v [2];

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    tp1_v = '{8'h9E, 8'h4F, 8'hC6};
    tp1_i = '{2'd2, 2'd1, 2'd3};
    tp2_v = '{8'h4F, 8'h63};
    build_tables();
    rst_n = 1'b0;
    idle_inputs();
    model_reset();
    repeat (2) @(negedge clk);
    check_all("reset");
    check("reset val_a", 64'(val_a), 64'h00FDFEFF);
    check("reset val_c", 64'(val_c), 64'hFFF);
    rst_n = 1'b1;

    // Single-step and double-step sequences from reset
    shift_a = 3'b001;
    for (int i = 0; i < 3; i++) begin
      shift_b = (i < 2) ? 2'b01 : 2'b00;
      run_cycle("step");
      check("step val_a0", 64'(val_a[7:0]), 64'(tp1_v[i]));
      check("step idx_a0", 64'(idx_a[1:0]), 64'(tp1_i[i]));
      if (i < 2) check("nstep2 val_b0", 64'(val_b[7:0]), 64'(tp2_v[i]));
    end
    idle_inputs();

    // Only channel 1 advances
    shift_a = 3'b010;
    run_cycle("multi");
    check("multi val_a", 64'(val_a), 64'h00FD7FC6);
    idle_inputs();

    // Seed load wins over a same-cycle shift
    seed_ld = 1'b1; chan_a = 2'd0; chan_b = 1'b1; chan_c = 1'b1;
    seed8 = 8'h5A; seed12 = 12'h5A5; shift_a = 3'b001;
    run_cycle("seed");
    check("seed val_a0", 64'(val_a[7:0]), 64'h5A);
    check("seed val_b1", 64'(val_b[15:8]), 64'h5A);
    check("seed ignored val_c", 64'(val_c), 64'hFFF);

    // Zero seed becomes all-ones
    chan_a = 2'd0; chan_b = 1'b0; chan_c = 1'b0; seed8 = 8'h00; seed12 = 12'h000;
    shift_c = 1'b1;
    run_cycle("seed0");
    check("seed0 val_a0", 64'(val_a[7:0]), 64'hFF);
    check("seed0 val_b0", 64'(val_b[7:0]), 64'hFF);
    check("seed0 val_c", 64'(val_c), 64'hFFF);

    // Out-of-range channel; load on b ch1 does not block shift on b ch0
    chan_a = 2'd3; seed8 = 8'h33; shift_a = 3'b000; shift_c = 1'b0;
    chan_b = 1'b1; shift_b = 2'b01; chan_c = 1'b1; seed12 = 12'h123;
    run_cycle("seedoor");
    check("seedoor val_a", 64'(val_a), 64'h00FD7FFF);
    check("seedoor val_b", 64'(val_b), 64'h334F);
    check("seedoor val_c", 64'(val_c), 64'hFFF);
    idle_inputs();

    // Asynchronous reset mid-stream
    shift_a = 3'b111; shift_b = 2'b11; shift_c = 1'b1;
    repeat (10) run_cycle("pre_rst");
    idle_inputs();
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst val_a", 64'(val_a), 64'h00FDFEFF);
    check("async_rst val_b", 64'(val_b), 64'hFEFF);
    check("async_rst val_c", 64'(val_c), 64'hFFF);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;

    // Randomized traffic
    for (int i = 0; i < 2000; i++) begin
      shift_a = 3'($urandom);
      shift_b = 2'($urandom);
      shift_c = 1'($urandom);
      seed_ld = ($urandom_range(0, 7) == 0);
      chan_a  = 2'($urandom);
      chan_b  = 1'($urandom);
      chan_c  = 1'($urandom);
      seed8   = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      seed12  = ($urandom_range(0, 3) == 0) ? 12'h000 : 12'($urandom);
      run_cycle("rand");
    end
    idle_inputs();

`ifdef HPDCACHE_PRNG_PERIOD_MON_EN
    // Full period from reset, then from a loaded seed
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    check("mon reset wrap", 64'(wrap_a), 64'h0);
    check("mon reset err", 64'(err_a), 64'h0);
    shift_a = 3'b001;
    for (int i = 1; i <= 255; i++) begin
      run_cycle("mon");
      check($sformatf("mon wrap_a0 cyc%0d", i), 64'(wrap_a[0]), 64'(i == 255));
    end
    check("mon period val", 64'(val_a[7:0]), 64'hFF);
    shift_a = 3'b000;
    run_cycle("mon_idle");
    check("mon wrap drop", 64'(wrap_a[0]), 64'h0);
    seed_ld = 1'b1; chan_a = 2'd0; seed8 = 8'h01;
    run_cycle("mon_seed");
    seed_ld = 1'b0;
    shift_a = 3'b001;
    for (int i = 1; i <= 255; i++) begin
      run_cycle("mon2");
      check($sformatf("mon2 wrap_a0 cyc%0d", i), 64'(wrap_a[0]), 64'(i == 255));
    end
    check("mon2 val", 64'(val_a[7:0]), 64'h01);
    check("mon err_a", 64'(err_a), 64'h0);
    idle_inputs();
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
